writeback_arbiter: RTL

- Producer side of the register file's single write port (addressw / writeData / writeEn).
- Merges two writeback sources into that port:
  - single-cycle ALU results, which always win the port;
  - variable-latency load responses, accepted through a valid/ready handshake and buffered in a small FIFO until the port is free.
- Also reports which destination registers still have a buffered load write, so decode can stall on RAW hazards.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_fifo.sv | 77 +++++++
 rtl/writeback_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file geometry and the writeback entry format used by the
// load-response buffer.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  // One buffered load write; valid drops when a younger ALU write squashes it.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with in-place squash by destination
// register and two combinational destination-match query ports.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic                          squash_en,
  input  logic [REG_ADDR_W-1:0]         squash_rd,
  input  logic [REG_ADDR_W-1:0]         q1_rd,
  input  logic [REG_ADDR_W-1:0]         q2_rd,
  output wb_entry_t                     head,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          q1_hit,
  output logic                          q2_hit
);

  localparam int PW = $clog2(FIFO_DEPTH);

  wb_entry_t       mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy. Popped slots have valid cleared so that
  // unoccupied slots never match a hazard query.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (squash_en) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (mem[i].rd == squash_rd) begin
            mem[i].valid <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      // The tail slot is never the head slot here: push only happens when
      // the buffer is not full, and pop only when it is not empty.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Destination-match lookups across all live entries.
  always_comb begin
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (mem[i].valid && (mem[i].rd == q1_rd)) q1_hit = 1'b1;
      if (mem[i].valid && (mem[i].rd == q2_rd)) q2_hit = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the register file's single write port from ALU results (always
// first) and buffered or bypassed load responses, and flags registers that
// still have a load write pending.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [$clog2(DEPTH)-1:0]      alu_rd,
  input  logic [BITS-1:0]               alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [$clog2(DEPTH)-1:0]      ld_rd,
  input  logic [BITS-1:0]               ld_data,
  input  logic [$clog2(DEPTH)-1:0]      q1_addr,
  input  logic [$clog2(DEPTH)-1:0]      q2_addr,
  output logic                          q1_pending,
  output logic                          q2_pending,
  output logic [$clog2(DEPTH)-1:0]      addressw,
  output logic [BITS-1:0]               writeData,
  output logic                          writeEn,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic            alu_win;
  logic            ld_fire;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            bypass;
  logic            sel_en;
  logic [AW-1:0]   sel_rd;
  logic [BITS-1:0] sel_data;
  logic            q1_hit;
  logic            q2_hit;
  wb_entry_t       head;
  wb_entry_t       push_entry;

  assign alu_win    = alu_valid && (alu_rd != '0);
  assign ld_ready   = (occupancy < OCC_W'(FIFO_DEPTH)) && !rst;
  assign ld_fire    = ld_valid && ld_ready;
  assign fifo_empty = (occupancy == '0);

  assign push_entry = '{valid: 1'b1, rd: ld_rd, data: ld_data};

  // Loads to x0 are dropped; a load racing an ALU write to the same register
  // is older than it and would be squashed anyway, so it is never stored.
  assign fifo_push  = ld_fire && (ld_rd != '0) && !bypass &&
                      !(alu_win && (ld_rd == alu_rd));

  assign q1_pending = (q1_addr != '0) && q1_hit;
  assign q2_pending = (q2_addr != '0) && q2_hit;

  // Priority select: ALU, then FIFO head (squashed heads pop silently), then
  // a load bypass when nothing is buffered.
  always_comb begin
    sel_en   = 1'b0;
    sel_rd   = alu_rd;
    sel_data = alu_data;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (alu_win) begin
      sel_en = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      sel_en   = head.valid;
      sel_rd   = head.rd;
      sel_data = head.data;
    end else if (ld_fire && (ld_rd != '0)) begin
      bypass   = 1'b1;
      sel_en   = 1'b1;
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end
  end

  // Write-port register; address and data hold their last issued values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeEn   <= 1'b0;
      addressw  <= '0;
      writeData <= '0;
    end else begin
      writeEn <= sel_en;
      if (sel_en) begin
        addressw  <= sel_rd;
        writeData <= sel_data;
      end
    end
  end

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .squash_en  (alu_win),
    .squash_rd  (alu_rd),
    .q1_rd      (q1_addr),
    .q2_rd      (q2_addr),
    .head       (head),
    .occupancy  (occupancy),
    .q1_hit     (q1_hit),
    .q2_hit     (q2_hit)
  );

endmodule
